// File: rtl/ibex_obi_rr_arbiter.sv
// ibex_obi_rr_arbiter: N-host to 1-device OBI arbiter, round-robin with request lock,
// in-order routing FIFO steering each response back to its issuing host.
module ibex_obi_rr_arbiter #(
    parameter int NumHosts       = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int IntgWidth      = 7,
    parameter int MaxOutstanding = 2,
    localparam int HostIdxW      = (NumHosts > 1) ? $clog2(NumHosts) : 1,
    localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumHosts-1:0]               host_req_i,
    output logic [NumHosts-1:0]               host_gnt_o,
    output logic [NumHosts-1:0]               host_rvalid_o,
    input  logic [NumHosts*AddrWidth-1:0]     host_addr_i,
    input  logic [NumHosts-1:0]               host_we_i,
    input  logic [NumHosts*DataWidth/8-1:0]   host_be_i,
    input  logic [NumHosts*DataWidth-1:0]     host_wdata_i,
    input  logic [NumHosts*IntgWidth-1:0]     host_wdata_intg_i,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic [IntgWidth-1:0]              host_rdata_intg_o,
    output logic                              host_err_o,
    output logic                              dev_req_o,
    input  logic                              dev_gnt_i,
    input  logic                              dev_rvalid_i,
    output logic [AddrWidth-1:0]              dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    output logic [IntgWidth-1:0]              dev_wdata_intg_o,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic [IntgWidth-1:0]              dev_rdata_intg_i,
    input  logic                              dev_err_i,
    output logic [CntW-1:0]                   outstanding_o,
    output logic                              unexpected_rvalid_o
);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int BeW  = DataWidth / 8;

    logic [HostIdxW-1:0] rr_q, lock_host_q, sel;
    logic                lock_q, err_q, any_req, full, empty, push, pop;
    logic [HostIdxW:0]   idx;
    logic [PtrW-1:0]     rd_q, wr_q;
    logic [CntW-1:0]     cnt_q;
    logic [HostIdxW-1:0] fifo_q [MaxOutstanding];

    // A still-requesting locked host wins; otherwise scan upward from rr_q with wrap.
    always_comb begin
        sel     = lock_host_q;
        any_req = lock_q && host_req_i[lock_host_q];
        idx     = '0;
        for (int i = 0; i < NumHosts; i++) begin
            idx = {1'b0, rr_q} + (HostIdxW + 1)'(i);
            idx = (idx >= (HostIdxW + 1)'(NumHosts)) ? idx - (HostIdxW + 1)'(NumHosts) : idx;
            if (!any_req && host_req_i[idx[HostIdxW-1:0]]) begin
                sel     = idx[HostIdxW-1:0];
                any_req = 1'b1;
            end
        end
    end

    assign full  = cnt_q == CntW'(MaxOutstanding);
    assign empty = cnt_q == '0;
    assign dev_req_o     = !rst_i && any_req && !full;
    assign push          = dev_req_o && dev_gnt_i;
    assign pop           = !rst_i && dev_rvalid_i && !empty;
    assign host_gnt_o    = push ? NumHosts'(1) << sel : '0;
    assign host_rvalid_o = pop ? NumHosts'(1) << fifo_q[rd_q] : '0;

    assign dev_addr_o       = host_addr_i[sel*AddrWidth +: AddrWidth];
    assign dev_we_o         = host_we_i[sel];
    assign dev_be_o         = host_be_i[sel*BeW +: BeW];
    assign dev_wdata_o      = host_wdata_i[sel*DataWidth +: DataWidth];
    assign dev_wdata_intg_o = host_wdata_intg_i[sel*IntgWidth +: IntgWidth];

    assign host_rdata_o        = dev_rdata_i;
    assign host_rdata_intg_o   = dev_rdata_intg_i;
    assign host_err_o          = dev_err_i;
    assign outstanding_o       = cnt_q;
    assign unexpected_rvalid_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_host_q <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            lock_q <= dev_req_o && !dev_gnt_i;
            if (dev_req_o && !dev_gnt_i) lock_host_q <= sel;
            if (push) begin
                fifo_q[wr_q] <= sel;
                wr_q         <= (wr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_q + 1'b1;
                rr_q         <= (sel == HostIdxW'(NumHosts - 1)) ? '0 : sel + 1'b1;
            end
            if (pop) rd_q <= (rd_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
            if (dev_rvalid_i && empty) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ibex_obi_rr_arbiter.sv
// tb_ibex_obi_rr_arbiter: randomized bench with a queue-based arbiter model and
// a response scoreboard drained by an independent monitor.
module tb_ibex_obi_rr_arbiter;
    localparam int NH = 2, AW = 32, DW = 32, IW = 7, MO = 2, BW = DW / 8;
    localparam int CW = $clog2(MO + 1);

    logic clk = 1'b0, rst = 1'b1;
    logic [NH-1:0] host_req_i = '0, host_gnt_o, host_rvalid_o, host_we_i = '0;
    logic [NH*AW-1:0] host_addr_i = '0;
    logic [NH*BW-1:0] host_be_i = '0;
    logic [NH*DW-1:0] host_wdata_i = '0;
    logic [NH*IW-1:0] host_wdata_intg_i = '0;
    logic [DW-1:0] host_rdata_o, dev_rdata_i = '0, dev_wdata_o;
    logic [IW-1:0] host_rdata_intg_o, dev_rdata_intg_i = '0, dev_wdata_intg_o;
    logic host_err_o, dev_req_o, dev_gnt_i = 1'b0, dev_rvalid_i = 1'b0, dev_we_o, dev_err_i = 1'b0;
    logic [AW-1:0] dev_addr_o;
    logic [BW-1:0] dev_be_o;
    logic [CW-1:0] outstanding_o;
    logic unexpected_rvalid_o;

    always #5 clk = ~clk;

    ibex_obi_rr_arbiter #(.NumHosts(NH), .AddrWidth(AW), .DataWidth(DW), .IntgWidth(IW),
                          .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_i(rst), .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
        .host_rvalid_o(host_rvalid_o), .host_addr_i(host_addr_i), .host_we_i(host_we_i),
        .host_be_i(host_be_i), .host_wdata_i(host_wdata_i), .host_wdata_intg_i(host_wdata_intg_i),
        .host_rdata_o(host_rdata_o), .host_rdata_intg_o(host_rdata_intg_o), .host_err_o(host_err_o),
        .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i),
        .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o),
        .dev_wdata_o(dev_wdata_o), .dev_wdata_intg_o(dev_wdata_intg_o),
        .dev_rdata_i(dev_rdata_i), .dev_rdata_intg_i(dev_rdata_intg_i), .dev_err_i(dev_err_i),
        .outstanding_o(outstanding_o), .unexpected_rvalid_o(unexpected_rvalid_o)
    );

    typedef struct {int host; logic [DW-1:0] rdata; logic [IW-1:0] intg; logic err;} rsp_t;

    int checks = 0, failures = 0;
    int rr = 0, lock_h = 0;
    bit lock_v = 0, err_m = 0;
    int mq[$];
    rsp_t exp_q[$];
    bit granted[NH];
    int p_req = 70, p_gnt = 60, p_rv = 50;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endfunction

    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (|host_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rvalid_unexpected actual=%b required=0", host_rvalid_o);
                end else begin
                    r = exp_q.pop_front();
                    chk("rvalid_route", 64'(host_rvalid_o), 64'(1) << r.host);
                    chk("rdata", 64'(host_rdata_o), 64'(r.rdata));
                    chk("rdata_intg", 64'(host_rdata_intg_o), 64'(r.intg));
                    chk("rsp_err", 64'(host_err_o), 64'(r.err));
                end
            end
        end
    end

    task automatic cycle(input bit force_rv);
        int sel, h;
        bit any, exp_req, hs, rv;
        @(negedge clk);
        for (int i = 0; i < NH; i++) begin
            if (!host_req_i[i] || granted[i]) begin
                host_req_i[i] = $urandom_range(99) < p_req;
                host_addr_i[i*AW +: AW]      = $urandom;
                host_we_i[i]                 = $urandom_range(1);
                host_be_i[i*BW +: BW]        = BW'($urandom);
                host_wdata_i[i*DW +: DW]     = $urandom;
                host_wdata_intg_i[i*IW +: IW] = IW'($urandom);
            end
            granted[i] = 0;
        end
        dev_gnt_i        = $urandom_range(99) < p_gnt;
        rv               = force_rv || (mq.size() > 0 && $urandom_range(99) < p_rv);
        dev_rvalid_i     = rv;
        dev_rdata_i      = $urandom;
        dev_rdata_intg_i = IW'($urandom);
        dev_err_i        = $urandom_range(1);
        #1;
        any = 0;
        sel = 0;
        if (lock_v && host_req_i[lock_h]) begin
            any = 1;
            sel = lock_h;
        end else begin
            for (int k = 0; k < NH; k++)
                if (!any && host_req_i[(rr + k) % NH]) begin
                    any = 1;
                    sel = (rr + k) % NH;
                end
        end
        exp_req = any && mq.size() < MO;
        hs = exp_req && dev_gnt_i;
        chk("dev_req", 64'(dev_req_o), 64'(exp_req));
        if (exp_req) begin
            chk("dev_addr", 64'(dev_addr_o), 64'(host_addr_i[sel*AW +: AW]));
            chk("dev_we", 64'(dev_we_o), 64'(host_we_i[sel]));
            chk("dev_be", 64'(dev_be_o), 64'(host_be_i[sel*BW +: BW]));
            chk("dev_wdata", 64'(dev_wdata_o), 64'(host_wdata_i[sel*DW +: DW]));
            chk("dev_wdata_intg", 64'(dev_wdata_intg_o), 64'(host_wdata_intg_i[sel*IW +: IW]));
        end
        chk("host_gnt", 64'(host_gnt_o), hs ? 64'(1) << sel : 64'(0));
        chk("outstanding", 64'(outstanding_o), 64'(mq.size()));
        chk("unexpected", 64'(unexpected_rvalid_o), 64'(err_m));
        if (rv) begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                exp_q.push_back('{h, dev_rdata_i, dev_rdata_intg_i, dev_err_i});
            end else err_m = 1;
        end
        if (hs) begin
            mq.push_back(sel);
            rr = (sel + 1) % NH;
            lock_v = 0;
            granted[sel] = 1;
        end else begin
            lock_v = exp_req;
            lock_h = sel;
        end
    endtask

    task automatic do_reset(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst = 1'b1;
            host_req_i = '1;
            dev_gnt_i = 1'b1;
            dev_rvalid_i = 1'b1;
            #1;
            chk("rst_dev_req", 64'(dev_req_o), 64'(0));
            chk("rst_gnt", 64'(host_gnt_o), 64'(0));
            chk("rst_rvalid", 64'(host_rvalid_o), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        host_req_i = '0;
        dev_gnt_i = 1'b0;
        dev_rvalid_i = 1'b0;
        mq.delete();
        rr = 0;
        lock_v = 0;
        err_m = 0;
        for (int i = 0; i < NH; i++) granted[i] = 0;
    endtask

    task automatic set_p(input int req, input int gnt, input int rv);
        p_req = req;
        p_gnt = gnt;
        p_rv = rv;
    endtask

    initial begin
        do_reset(2);
        set_p(100, 100, 100); repeat (20) cycle(0);
        set_p(70, 50, 40);    repeat (400) cycle(0);
        // saturate the FIFO, then trickle responses so a pop coincides with a blocked issue
        set_p(100, 100, 0);   repeat (5) cycle(0);
        set_p(100, 100, 50);  repeat (40) cycle(0);
        set_p(0, 0, 100);     repeat (6) cycle(0);
        cycle(1);
        set_p(0, 0, 0);       repeat (3) cycle(0);
        do_reset(1);
        repeat (2) cycle(0);
        set_p(100, 100, 0);   repeat (4) cycle(0);
        do_reset(1);
        set_p(0, 0, 0);
        cycle(1);
        repeat (2) cycle(0);
        do_reset(1);
        set_p(80, 70, 50);    repeat (400) cycle(0);
        set_p(0, 0, 100);     repeat (8) cycle(0);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
